// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   8N1 serial receive front end. Synchronises rx_i, detects start bits,
//   samples each frame at a runtime-programmable bit period and presents
//   completed bytes through a one-entry valid/ready holding register.
//
// Ports
//   clk_i        system clock
//   arst_i       asynchronous active-high reset
//   rx_i         serial line, idle high, asynchronous to clk_i
//   bitperiod_i  clock cycles per bit (floored at MIN_BITPERIOD)
//   data_o       received byte (LSB first on the line)
//   valid_o      data_o holds an unconsumed byte
//   ready_i      downstream accepts when valid_o && ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: completed byte dropped, holding register full
module uart_rx_deser #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_BITPERIOD = 4
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        rx_i,
  input  logic [31:0] bitperiod_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overrun_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            period_q, period_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;

  logic        rx_s;
  logic [31:0] p_eff;
  logic [31:0] half;
  logic        last_tick;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign p_eff     = (bitperiod_i < 32'(MIN_BITPERIOD)) ? 32'(MIN_BITPERIOD) : bitperiod_i;
  assign half      = (period_q >> 1) - 32'd1;
  assign last_tick = (cnt_q == period_q - 32'd1);

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rx_i};
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    period_d = period_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    // An accepted byte frees the holding register; a load below overrides.
    valid_d  = valid_q && !ready_i;
    fe_d     = 1'b0;
    ov_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          // Period is captured here so mid-frame changes only affect the next frame.
          period_d = p_eff;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == half) begin
          cnt_d = '0;
          if (!rx_s) begin
            idx_d   = 3'd0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            if (!valid_q || ready_i) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Holding here until the line returns high limits a break to one error.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q   <= '1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = fe_q;
  assign overrun_o   = ov_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
//   Directed bench for uart_rx_deser: reset values, single byte with exact
//   latency, glitch rejection, framing error/break, overrun with
//   backpressure, back-to-back frames at the minimum period and reset
//   in the middle of a frame.
module tb_uart_rx_deser;

  logic        clk = 1'b0;
  logic        arst_i;
  logic        rx_i;
  logic [31:0] bitperiod_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        frame_err_o;
  logic        overrun_o;

  int checks = 0;
  int errors = 0;

  uart_rx_deser #(.SYNC_STAGES(2), .MIN_BITPERIOD(4)) dut (
    .clk_i       (clk),
    .arst_i      (arst_i),
    .rx_i        (rx_i),
    .bitperiod_i (bitperiod_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  // Cycle counter and output monitor (sampled on the falling edge).
  int         cyc = 0;
  logic [7:0] acc[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vr_cnt = 0;
  int         stab_err = 0;
  int         rise_cyc = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o && ready_i) acc.push_back(data_o);
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (valid_o && !prev_v) begin
      vr_cnt++;
      if (rise_cyc == 0) rise_cyc = cyc;
    end
    if (!arst_i && prev_v && !prev_r && (!valid_o || data_o !== prev_d)) stab_err++;
    prev_v = valid_o;
    prev_r = ready_i;
    prev_d = data_o;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p);
    logic [7:0] bb;
    bb = b;
    rx_i = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      rx_i = bb[i];
      tick(p);
    end
    rx_i = stop_bit;
    tick(p);
  endtask

  int fall_cyc;
  int n0, fe0, ov0, vr0;

  initial begin
    arst_i      = 1'b1;
    rx_i        = 1'b1;
    bitperiod_i = 32'd868;
    ready_i     = 1'b1;
    tick(3);

    // Reset values
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_fe", 32'(frame_err_o), 32'h0);
    check("rst_ov", 32'(overrun_o), 32'h0);
    arst_i = 1'b0;
    tick(5);

    // Single byte at P=868; valid rises SYNC+H+9P+2 = 2+433+7812+2 cycles after the edge
    n0       = acc.size();
    rise_cyc = 0;
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, 868);
    tick(50);
    check("single_count", 32'(acc.size() - n0), 32'd1);
    if (acc.size() > n0) check("single_data", 32'(acc[n0]), 32'hA5);
    check("single_latency", 32'(rise_cyc - fall_cyc), 32'd8249);
    check("single_valid_low", 32'(valid_o), 32'h0);
    check("single_fe", 32'(fe_cnt), 32'd0);
    check("single_ov", 32'(ov_cnt), 32'd0);

    // Glitch: 100 low cycles is rejected at the start sample
    vr0  = vr_cnt;
    rx_i = 1'b0;
    tick(100);
    rx_i = 1'b1;
    tick(1200);
    check("glitch_valid", 32'(vr_cnt - vr0), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);
    check("glitch_ov", 32'(ov_cnt), 32'd0);

    // Framing error then break, then a clean byte at P=16
    bitperiod_i = 32'd16;
    n0  = acc.size();
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 16);
    tick(48);
    rx_i = 1'b1;
    tick(32);
    send_frame(8'h81, 1'b1, 16);
    tick(32);
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_count", 32'(acc.size() - n0), 32'd1);
    if (acc.size() > n0) check("ferr_next_data", 32'(acc[n0]), 32'h81);

    // Overrun with backpressure
    ready_i = 1'b0;
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    n0  = acc.size();
    send_frame(8'h55, 1'b1, 16);
    send_frame(8'h3C, 1'b1, 16);
    tick(32);
    check("ovr_valid", 32'(valid_o), 32'h1);
    check("ovr_data", 32'(data_o), 32'h55);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_fe", 32'(fe_cnt - fe0), 32'd0);
    check("ovr_stable", 32'(stab_err), 32'd0);
    ready_i = 1'b1;
    tick(1);
    check("ovr_valid_drop", 32'(valid_o), 32'h0);
    check("ovr_accept_count", 32'(acc.size() - n0), 32'd1);
    if (acc.size() > n0) check("ovr_accept_data", 32'(acc[n0]), 32'h55);

    // Back-to-back at the minimum period (1 clamps to 4)
    bitperiod_i = 32'd1;
    tick(8);
    n0  = acc.size();
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b1, 4);
    send_frame(8'hFF, 1'b1, 4);
    send_frame(8'h5A, 1'b1, 4);
    tick(16);
    check("b2b_count", 32'(acc.size() - n0), 32'd3);
    if (acc.size() >= n0 + 3) begin
      check("b2b_data0", 32'(acc[n0]), 32'h00);
      check("b2b_data1", 32'(acc[n0+1]), 32'hFF);
      check("b2b_data2", 32'(acc[n0+2]), 32'h5A);
    end
    check("b2b_fe", 32'(fe_cnt - fe0), 32'd0);
    check("b2b_ov", 32'(ov_cnt - ov0), 32'd0);

    // Reset mid-frame: hold a byte, start 0xC3, reset during data bit 4
    bitperiod_i = 32'd16;
    ready_i     = 1'b0;
    tick(8);
    send_frame(8'h11, 1'b1, 16);
    tick(8);
    check("mrst_pre_valid", 32'(valid_o), 32'h1);
    check("mrst_pre_data", 32'(data_o), 32'h11);
    n0  = acc.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_i = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx_i = (i < 2) ? 1'b1 : 1'b0;
      tick(16);
    end
    rx_i = 1'b0;
    tick(8);
    arst_i = 1'b1;
    #1;
    check("mrst_valid", 32'(valid_o), 32'h0);
    check("mrst_data", 32'(data_o), 32'h00);
    check("mrst_fe", 32'(frame_err_o), 32'h0);
    check("mrst_ov", 32'(overrun_o), 32'h0);
    rx_i = 1'b1;
    tick(3);
    arst_i  = 1'b0;
    ready_i = 1'b1;
    tick(32);
    send_frame(8'h96, 1'b1, 16);
    tick(32);
    check("mrst_count", 32'(acc.size() - n0), 32'd1);
    if (acc.size() > n0) check("mrst_next_data", 32'(acc[n0]), 32'h96);
    check("mrst_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
    check("mrst_ov_cnt", 32'(ov_cnt - ov0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
